// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and the round-robin pick function for the memory request arbiter.
// The default requester count sizes req_id_t for code that uses the stock configuration.
package mem_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 2;
  localparam int MAX_REQ         = 32;
  localparam int MAX_REQ_IDX_W   = 5;

  typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] req_id_t;

  // Offsets are scanned from farthest to nearest, so the nearest active requester
  // at or after ptr is the one left in rr_pick.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned idx;
    rr_pick = ptr;
    for (int unsigned off = MAX_REQ; off > 0; off--) begin
      if (off <= n) begin
        idx = ptr + off - 1;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (req[idx[MAX_REQ_IDX_W-1:0]]) begin
          rr_pick = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the memory.
interface mem_req_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]                req_i;
  logic [NUM_REQ-1:0]                gnt_o;
  logic [NUM_REQ*ADDR_WIDTH-1:0]     addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0]     wdata_i;
  logic [NUM_REQ*DATA_WIDTH/8-1:0]   strb_i;
  logic [NUM_REQ-1:0]                we_i;
  logic [NUM_REQ-1:0]                rvalid_o;
  logic [DATA_WIDTH-1:0]             rdata_o;

  logic                              mem_req_o;
  logic                              mem_gnt_i;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic [DATA_WIDTH-1:0]             mem_wdata_o;
  logic [DATA_WIDTH/8-1:0]           mem_strb_o;
  logic                              mem_we_o;
  logic                              mem_rvalid_i;
  logic [DATA_WIDTH-1:0]             mem_rdata_i;

  modport slave (
    input  req_i, addr_i, wdata_i, strb_i, we_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_we_o
  );

  modport master (
    output req_i, addr_i, wdata_i, strb_i, we_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_strb_o, mem_we_o
  );

endinterface

// File: rtl/mem_req_arbiter_id_fifo.sv
// FIFO of requester IDs for accepted-but-unanswered memory requests.
// Storage is not reset; only pointers and count are.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == (PTR_W+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between NUM_REQ requesters,
// routing in-order responses back to whichever requester won each request.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ         = DEFAULT_NUM_REQ,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_req_arbiter_if.slave  bus,
  output logic              busy_o,
  output logic              err_o
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             handshake;
  logic             resp_pop;

  assign winner = ID_W'(rr_pick(MAX_REQ'(bus.req_i), 32'(ptr), NUM_REQ));

  // Gating with rst_ni keeps the memory port quiet while reset is held, even with requests pending.
  assign bus.mem_req_o = rst_ni & (|bus.req_i) & ~fifo_full;
  assign handshake     = bus.mem_req_o & bus.mem_gnt_i;
  assign resp_pop      = rst_ni & bus.mem_rvalid_i & ~fifo_empty;
  assign bus.rdata_o   = bus.mem_rdata_i;
  assign busy_o        = (fifo_count != '0);

  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_strb_o  = '0;
    bus.mem_we_o    = 1'b0;
    bus.gnt_o       = '0;
    bus.rvalid_o    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        bus.mem_addr_o  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_wdata_o = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        bus.mem_strb_o  = bus.strb_i[k*STRB_W +: STRB_W];
        bus.mem_we_o    = bus.we_i[k];
        bus.gnt_o[k]    = handshake;
      end
      if (head == ID_W'(k)) begin
        bus.rvalid_o[k] = resp_pop;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // A response with nothing outstanding means the memory and arbiter have lost sync; latch it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (bus.mem_rvalid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (handshake),
    .push_data (winner),
    .pop       (resp_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
